// File: rtl/rvvi_trace_pkg.sv
// Shared types and bounds for the RVVI retirement trace buffer.
package rvvi_trace_pkg;

  localparam int XLEN_MAX  = 64;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 64;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [63:0]         order;
    logic [31:0]         insn;
    logic [XLEN_MAX-1:0] pc;
    logic                trap;
    logic [1:0]          mode;
  } trace_rec_t;

  typedef enum logic {
    CHK_IDLE  = 1'b0,
    CHK_TRACK = 1'b1
  } chk_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rvvi_trace_buffer_if.sv
// Producer/consumer bundle of the trace buffer: retirement input, head output and status.
interface rvvi_trace_buffer_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            clr;
  logic            in_valid;
  logic [63:0]     in_order;
  logic [31:0]     in_insn;
  logic [XLEN-1:0] in_pc;
  logic            in_trap;
  logic [1:0]      in_mode;

  logic            out_valid;
  logic            out_ready;
  logic [63:0]     out_order;
  logic [31:0]     out_insn;
  logic [XLEN-1:0] out_pc;
  logic            out_trap;
  logic [1:0]      out_mode;

  logic [CW-1:0]   count;
  logic            overflow;
  logic            order_err;
  logic [63:0]     err_order;
  logic [31:0]     retired_cnt;
  logic [31:0]     trap_cnt;

  modport master (
    output clr, in_valid, in_order, in_insn, in_pc, in_trap, in_mode, out_ready,
    input  out_valid, out_order, out_insn, out_pc, out_trap, out_mode,
    input  count, overflow, order_err, err_order, retired_cnt, trap_cnt
  );

  modport slave (
    input  clr, in_valid, in_order, in_insn, in_pc, in_trap, in_mode, out_ready,
    output out_valid, out_order, out_insn, out_pc, out_trap, out_mode,
    output count, overflow, order_err, err_order, retired_cnt, trap_cnt
  );

endinterface

// File: rtl/rvvi_trace_fifo.sv
// Generic synchronous FIFO with occupancy count; a full FIFO still accepts a write when a read
// happens in the same cycle, otherwise the write is reported as dropped.
module rvvi_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr_i,
  input  logic                   wr_req_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   rd_req_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   push_o,
  output logic                   drop_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             pop;

  always_comb begin
    pop    = rd_req_i && (count_q != '0) && !clr_i;
    push_o = wr_req_i && ((count_q != FULL_CNT) || pop) && !clr_i;
    drop_o = wr_req_i && !push_o && !clr_i;
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_o) wptr_d = wptr_q + AW'(1);
      if (pop)    rptr_d = rptr_q + AW'(1);
      count_d = count_q + {{AW{1'b0}}, push_o} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_o) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rvvi_trace_buffer.sv
// Retirement trace buffer: queues RVVI records for a coverage sampler, checks order-number
// continuity and keeps sticky error flags plus saturating retirement/trap counters.
module rvvi_trace_buffer #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 8
) (
  input logic                clk,
  input logic                reset,
  rvvi_trace_buffer_if.slave bus
);
  import rvvi_trace_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  trace_rec_t    in_rec, head_rec;
  logic [CW-1:0] count;
  logic          push, drop, seq_err;

  chk_state_e    state_q, state_d;
  logic [63:0]   expected_q, expected_d;
  logic          overflow_q, overflow_d, order_err_q, order_err_d;
  logic [63:0]   err_order_q, err_order_d;
  logic [31:0]   retired_cnt_q, retired_cnt_d, trap_cnt_q, trap_cnt_d;

  always_comb begin
    in_rec.order = bus.in_order;
    in_rec.insn  = bus.in_insn;
    in_rec.pc    = XLEN_MAX'(bus.in_pc);
    in_rec.trap  = bus.in_trap;
    in_rec.mode  = bus.in_mode;
  end

  rvvi_trace_fifo #(
    .WIDTH($bits(trace_rec_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (bus.clr),
    .wr_req_i (bus.in_valid),
    .wdata_i  (in_rec),
    .rd_req_i (bus.out_ready),
    .rdata_o  (head_rec),
    .count_o  (count),
    .push_o   (push),
    .drop_o   (drop)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CHK_IDLE;
      expected_q <= '0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
    end
  end

  // Dropped records still move the expected order, so a drop alone never raises order_err.
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    case (state_q)
      CHK_IDLE: begin
        if (bus.in_valid) begin
          state_d    = CHK_TRACK;
          expected_d = bus.in_order + 64'd1;
        end
      end
      CHK_TRACK: begin
        if (bus.in_valid) expected_d = bus.in_order + 64'd1;
      end
      default: state_d = CHK_IDLE;
    endcase
    if (bus.clr) begin
      state_d    = CHK_IDLE;
      expected_d = '0;
    end
  end

  always_comb begin
    seq_err = 1'b0;
    case (state_q)
      CHK_TRACK: seq_err = bus.in_valid && !bus.clr && (bus.in_order != expected_q);
      default:   seq_err = 1'b0;
    endcase
  end

  always_comb begin
    overflow_d    = overflow_q;
    order_err_d   = order_err_q;
    err_order_d   = err_order_q;
    retired_cnt_d = retired_cnt_q;
    trap_cnt_d    = trap_cnt_q;
    if (bus.clr) begin
      overflow_d    = 1'b0;
      order_err_d   = 1'b0;
      err_order_d   = '0;
      retired_cnt_d = '0;
      trap_cnt_d    = '0;
    end else begin
      if (drop) overflow_d = 1'b1;
      if (seq_err) begin
        order_err_d = 1'b1;
        if (!order_err_q) err_order_d = bus.in_order;
      end
      if (push) begin
        retired_cnt_d = sat_inc(retired_cnt_q);
        if (bus.in_trap) trap_cnt_d = sat_inc(trap_cnt_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q    <= 1'b0;
      order_err_q   <= 1'b0;
      err_order_q   <= '0;
      retired_cnt_q <= '0;
      trap_cnt_q    <= '0;
    end else begin
      overflow_q    <= overflow_d;
      order_err_q   <= order_err_d;
      err_order_q   <= err_order_d;
      retired_cnt_q <= retired_cnt_d;
      trap_cnt_q    <= trap_cnt_d;
    end
  end

  assign bus.out_valid   = (count != '0);
  assign bus.out_order   = head_rec.order;
  assign bus.out_insn    = head_rec.insn;
  assign bus.out_pc      = head_rec.pc[XLEN-1:0];
  assign bus.out_trap    = head_rec.trap;
  assign bus.out_mode    = head_rec.mode;
  assign bus.count       = count;
  assign bus.overflow    = overflow_q;
  assign bus.order_err   = order_err_q;
  assign bus.err_order   = err_order_q;
  assign bus.retired_cnt = retired_cnt_q;
  assign bus.trap_cnt    = trap_cnt_q;

endmodule

// File: tb/tb_rvvi_trace_buffer.sv
// Scoreboard bench for rvvi_trace_buffer: directed scenarios followed by randomized traffic,
// checked against a queue-based model of the buffer, order checker and counters.
module tb_rvvi_trace_buffer;
  import rvvi_trace_pkg::*;

  localparam int XLEN  = 64;
  localparam int DEPTH = 8;
  localparam longint unsigned SAT = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rvvi_trace_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  rvvi_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: expQ doubles as the scoreboard of records the sampler must see, in order.
  trace_rec_t      expQ[$];
  int              mOcc;
  bit              mTracking;
  logic [63:0]     mExpected;
  bit              mOverflow;
  bit              mOrderErr;
  logic [63:0]     mErrOrder;
  longint unsigned mRetired;
  longint unsigned mTrap;

  task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelClear();
    expQ.delete();
    mOcc      = 0;
    mTracking = 0;
    mExpected = '0;
    mOverflow = 0;
    mOrderErr = 0;
    mErrOrder = '0;
    mRetired  = 0;
    mTrap     = 0;
  endtask

  task automatic checkOutput();
    checkValue("out_valid",   64'(bus.out_valid),   64'(mOcc != 0));
    checkValue("count",       64'(bus.count),       64'(mOcc));
    checkValue("overflow",    64'(bus.overflow),    64'(mOverflow));
    checkValue("order_err",   64'(bus.order_err),   64'(mOrderErr));
    checkValue("err_order",   bus.err_order,        mErrOrder);
    checkValue("retired_cnt", 64'(bus.retired_cnt), mRetired);
    checkValue("trap_cnt",    64'(bus.trap_cnt),    mTrap);
  endtask

  // Called at posedge+1: checks current state, drives one cycle of inputs, advances the model.
  task automatic applyStimulus(input bit vld, input logic [63:0] order, input bit trap,
                               input bit ready, input bit clrIn);
    trace_rec_t rec;
    bit popNow;
    bit acc;
    checkOutput();
    rec.order = order;
    rec.insn  = $urandom;
    rec.pc    = {$urandom, $urandom};
    rec.trap  = trap;
    rec.mode  = 2'($urandom_range(0, 3));
    bus.clr       = clrIn;
    bus.in_valid  = vld;
    bus.in_order  = rec.order;
    bus.in_insn   = rec.insn;
    bus.in_pc     = rec.pc[XLEN-1:0];
    bus.in_trap   = rec.trap;
    bus.in_mode   = rec.mode;
    bus.out_ready = ready;
    if (clrIn) begin
      modelClear();
    end else begin
      popNow = ready && (mOcc > 0);
      acc    = 0;
      if (vld) begin
        if (mTracking && order != mExpected) begin
          if (!mOrderErr) mErrOrder = order;
          mOrderErr = 1;
        end
        mTracking = 1;
        mExpected = order + 64'd1;
        if (mOcc < DEPTH || popNow) begin
          acc = 1;
          expQ.push_back(rec);
          if (mRetired < SAT) mRetired++;
          if (trap && mTrap < SAT) mTrap++;
        end else begin
          mOverflow = 1;
        end
      end
      mOcc = mOcc + int'(acc) - int'(popNow);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n, input bit ready);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 64'd0, 1'b0, ready, 1'b0);
  endtask

  // Monitor: the head must always match the oldest outstanding record; pops consume it.
  initial begin
    trace_rec_t head;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.clr === 1'b0 && bus.out_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL head_unexpected: got order 0x%0h, expected no record at %0t", bus.out_order, $time);
        end else begin
          head = expQ[0];
          checkValue("head_order", bus.out_order,      head.order);
          checkValue("head_insn",  64'(bus.out_insn),  64'(head.insn));
          checkValue("head_pc",    64'(bus.out_pc),    64'(head.pc[XLEN-1:0]));
          checkValue("head_trap",  64'(bus.out_trap),  64'(head.trap));
          checkValue("head_mode",  64'(bus.out_mode),  64'(head.mode));
          if (bus.out_ready === 1'b1) void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] nextOrder;
    int readyPct;
    bit vld;
    logic [63:0] ord;

    reset = 1'b1;
    bus.clr = 0; bus.in_valid = 0; bus.in_order = '0; bus.in_insn = '0;
    bus.in_pc = '0; bus.in_trap = 0; bus.in_mode = '0; bus.out_ready = 0;
    modelClear();
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    reset = 1'b0;

    $display("[TB] in-order drain of four records");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 64'(i), 1'b0, 1'b0, 1'b0);
    checkValue("fill4_count", 64'(bus.count), 64'd4);
    idleCycles(4, 1'b1);
    checkValue("drain4_count", 64'(bus.count), 64'd0);
    checkValue("drain4_retired", 64'(bus.retired_cnt), 64'd4);

    $display("[TB] overflow on ninth record");
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 64'(100 + i), 1'b0, 1'b0, 1'b0);
    checkValue("ovf_count", 64'(bus.count), 64'd8);
    checkValue("ovf_flag", 64'(bus.overflow), 64'd1);
    checkValue("ovf_retired", 64'(bus.retired_cnt), 64'd8);
    idleCycles(9, 1'b1);

    $display("[TB] full with simultaneous push and pop");
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 64'(200 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'd208, 1'b0, 1'b1, 1'b0);
    checkValue("fullpp_count", 64'(bus.count), 64'd8);
    checkValue("fullpp_overflow", 64'(bus.overflow), 64'd0);
    idleCycles(9, 1'b1);

    $display("[TB] order gap detection");
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 64'd10, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 64'd11, 1'b0, 1'b1, 1'b0);
    checkValue("gap_before", 64'(bus.order_err), 64'd0);
    applyStimulus(1'b1, 64'd13, 1'b0, 1'b1, 1'b0);
    checkValue("gap_flag", 64'(bus.order_err), 64'd1);
    checkValue("gap_err_order", bus.err_order, 64'd13);
    applyStimulus(1'b1, 64'd14, 1'b0, 1'b1, 1'b0);
    checkValue("gap_err_order_kept", bus.err_order, 64'd13);
    idleCycles(2, 1'b1);

    $display("[TB] clear with buffered records");
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 64'(300 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'd999, 1'b0, 1'b0, 1'b1);
    checkValue("clr_count", 64'(bus.count), 64'd0);
    checkValue("clr_retired", 64'(bus.retired_cnt), 64'd0);
    applyStimulus(1'b1, 64'd5000, 1'b0, 1'b0, 1'b0);
    checkValue("clr_idle_no_err", 64'(bus.order_err), 64'd0);
    idleCycles(2, 1'b1);

    $display("[TB] asynchronous reset mid-cycle");
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 64'd400, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'd401, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'd402, 1'b1, 1'b0, 1'b0);
    checkValue("rst_trap_before", 64'(bus.trap_cnt), 64'd2);
    bus.in_valid = 0;
    #2;
    reset = 1'b1;
    modelClear();
    #1;
    checkValue("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkValue("rst_count", 64'(bus.count), 64'd0);
    checkValue("rst_trap_cnt", 64'(bus.trap_cnt), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b1, 64'd7000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'd7001, 1'b1, 1'b1, 1'b0);
    checkValue("rst_reenter_no_err", 64'(bus.order_err), 64'd0);
    idleCycles(3, 1'b1);

    $display("[TB] randomized traffic");
    nextOrder = 64'd1000;
    for (int seg = 0; seg < 4; seg++) begin
      readyPct = (seg == 0) ? 20 : (seg == 1) ? 90 : (seg == 2) ? 50 : 70;
      for (int i = 0; i < 150; i++) begin
        vld = ($urandom_range(0, 99) < 75);
        ord = ($urandom_range(0, 15) == 0) ? nextOrder + 64'($urandom_range(1, 3)) : nextOrder;
        if (vld) nextOrder = ord + 64'd1;
        applyStimulus(vld, ord, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 99) < readyPct), ($urandom_range(0, 99) == 0));
      end
    end
    idleCycles(10, 1'b1);
    checkValue("final_drained", 64'(expQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/rvvi_trace_buffer.md
RVVI_TRACE_BUFFER -- requirements
Module: rvvi_trace_buffer

Interface
REQ-001 Parameter XLEN, default 64, width of PC field (32 or 64).
REQ-002 Parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 clr  input  1  synchronous clear of FIFO, counters and error flags.
REQ-006 in_valid  input  1  one retired-instruction record presented this cycle; no backpressure.
REQ-007 in_order  input  64  retirement order number.
REQ-008 in_insn  input  32  instruction encoding.
REQ-009 in_pc  input  XLEN  instruction PC.
REQ-010 in_trap  input  1  instruction trapped.
REQ-011 in_mode  input  2  privilege mode.
REQ-012 out_valid  output  1  FIFO head record valid.
REQ-013 out_ready  input  1  consumer (coverage sampler) accepts head.
REQ-014 out_order/out_insn/out_pc/out_trap/out_mode  output  64/32/XLEN/1/2  head record fields.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 overflow  output  1  sticky: a record was dropped.
REQ-017 order_err  output  1  sticky: out-of-sequence order number seen.
REQ-018 err_order  output  64  in_order of first out-of-sequence record.
REQ-019 retired_cnt, trap_cnt  output  32 each  saturating counts of accepted records / accepted records with in_trap=1.

Function
REQ-020 Push occurs when in_valid=1 and (count<DEPTH or pop occurs same cycle).
REQ-021 Pop occurs when out_valid=1 and out_ready=1; head advances next cycle.
REQ-022 out_valid SHALL equal (count!=0); head fields SHALL be registered FIFO storage, stable while out_valid=1 and out_ready=0.
REQ-023 Latency: record pushed in cycle N appears at head in cycle N+1 when FIFO was empty; no bypass.
REQ-024 Full, push and pop same cycle: both occur, count unchanged, no overflow.
REQ-025 Full, push without pop: record dropped, overflow set, count and storage unchanged, counters unchanged.
REQ-026 Empty with out_ready=1: no pop, no state change.
REQ-027 Read/write pointers wrap modulo DEPTH.
REQ-028 Order checker states: IDLE (no record seen) and TRACK (expected order held); IDLE->TRACK on first push, expected=in_order+1.
REQ-029 In TRACK, any in_valid with in_order!=expected sets order_err; err_order captured only on first error; expected then resynchronises to in_order+1.
REQ-030 Order check evaluates every in_valid including dropped records.
REQ-031 retired_cnt increments per push; trap_cnt per push with in_trap=1; both saturate at 0xFFFF_FFFF.
REQ-032 clr=1 takes priority over push/pop that cycle: count=0, pointers=0, checker->IDLE, flags and counters zeroed, input record discarded.

Reset
REQ-033 reset asserted SHALL immediately force: count=0, out_valid=0, pointers=0, checker IDLE, overflow=0, order_err=0, err_order=0, retired_cnt=0, trap_cnt=0.
REQ-034 FIFO storage and out_* data fields need not be reset; out_* fields are don't-care while out_valid=0.
REQ-035 Reset mid-operation discards all buffered records; first record after deassertion re-enters IDLE->TRACK.

Structure
REQ-036 Record struct type (order, insn, pc, trap, mode) and DEPTH bound constants SHALL live in shared package rvvi_trace_pkg, parameterised-width PC handled by XLEN-max field.
REQ-037 One sub-module, rvvi_trace_fifo (generic synchronous FIFO with count), SHALL hold storage/pointers; order checker and counters stay in top.

Verification
REQ-038 Push orders 0..3 with out_ready=0, then out_ready=1 -> out_order 0,1,2,3 on consecutive cycles, count 4->0, retired_cnt=4.
REQ-039 DEPTH=8, push 9 records with out_ready=0 -> count=8, overflow=1, 9th record never appears, retired_cnt=8.
REQ-040 FIFO full, in_valid=1 and out_ready=1 same cycle -> count stays 8, overflow=0.
REQ-041 Orders 10,11,13,14 -> order_err=1 after the 13 record, err_order=13, no further error on 14.
REQ-042 Three pushes with in_trap=1,0,1 then reset asserted mid-cycle -> out_valid, count, trap_cnt zero without a clock edge; trap_cnt was 2 before reset.
REQ-043 clr=1 with in_valid=1 and 5 entries buffered -> next cycle count=0, retired_cnt=0, checker IDLE (next order value accepted without error).
